vga_dac_driver: RTL and testbench

Parametrised raster timing generator and DAC code driver for the current-steering and segmented video DACs. It generates sync, blanking, pixel position and a test-pattern colour for R/G/B. Each channel is emitted as a binary code, its bitwise complement and a 2-bit-group thermometer code. All outputs are registered on the same edge so the analog switch inputs change glitch-aligned.

---
 rtl/vga_dac_driver.sv | 125 ++++++++++++
 tb/tb_vga_dac_driver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dac_driver.sv
// vga_dac_driver: raster timing generator with registered binary, complement and thermometer DAC codes
module vga_dac_driver #(
  parameter int CW = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic [9:0]        hpos,
  output logic [9:0]        vpos,
  output logic              frame_start,
  output logic [CW-1:0]     r,
  output logic [CW-1:0]     g,
  output logic [CW-1:0]     b,
  output logic [CW-1:0]     rn,
  output logic [CW-1:0]     gn,
  output logic [CW-1:0]     bn,
  output logic [3*CW/2-1:0] r_th,
  output logic [3*CW/2-1:0] g_th,
  output logic [3*CW/2-1:0] b_th
);
  localparam int TW = 3 * CW / 2;
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VT1 = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] BL = 10'(H_ACTIVE / 8 - 1);
  logic [9:0] hc, vc, pc, fcx;
  logic [10:0] hx, vx;
  logic [2:0] bar;
  logic [7:0] fc;
  logic [1:0] mode_q, m;
  logic h_wrap, v_wrap, origin, hb, vb, hs, vs, chk;
  logic [CW-1:0] on, rc, gc, bc;
  function automatic logic [TW-1:0] therm(input logic [CW-1:0] c);
    therm = '0;
    for (int k = 0; k < CW / 2; k++)
      therm[3*k +: 3] = {c[2*k+1] & c[2*k], c[2*k+1], c[2*k+1] | c[2*k]};
  endfunction
  assign hx = {1'b0, hc};
  assign vx = {1'b0, vc};
  assign fcx = {2'b00, fc};
  assign on = '1;
  // The origin pixel already uses the mode being latched on that edge.
  always_comb begin
    h_wrap = hx == HT1;
    v_wrap = vx == VT1;
    origin = hc == 10'd0 && vc == 10'd0;
    m = origin ? mode : mode_q;
    hb = hx >= HA;
    vb = vx >= VA;
    hs = hx >= HS0 && hx < HS1;
    vs = vx >= VS0 && vx < VS1;
    chk = hc[4] ^ vc[4];
    rc = (hb || vb) ? '0 : m == 2'd1 ? hc[CW-1:0] : m == 2'd2 ? (bar[2] ? on : '0) : m == 2'd3 ? (chk ? on : '0) : '0;
    gc = (hb || vb) ? '0 : m == 2'd1 ? vc[CW-1:0] : m == 2'd2 ? (bar[1] ? on : '0) : m == 2'd3 ? (chk ? on : '0) : '0;
    bc = (hb || vb) ? '0 : m == 2'd1 ? fcx[CW-1:0] : m == 2'd2 ? (bar[0] ? on : '0) : m == 2'd3 ? (chk ? on : '0) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
      pc <= '0;
      bar <= '0;
      fc <= '0;
      mode_q <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      hblank <= 1'b0;
      vblank <= 1'b0;
      hpos <= '0;
      vpos <= '0;
      frame_start <= 1'b0;
      r <= '0;
      g <= '0;
      b <= '0;
      rn <= '1;
      gn <= '1;
      bn <= '1;
      r_th <= '0;
      g_th <= '0;
      b_th <= '0;
    end else if (en) begin
      hc <= h_wrap ? 10'd0 : hc + 10'd1;
      if (h_wrap) vc <= v_wrap ? 10'd0 : vc + 10'd1;
      if (h_wrap && v_wrap) fc <= fc + 8'd1;
      if (origin) mode_q <= mode;
      pc <= (h_wrap || pc == BL) ? 10'd0 : pc + 10'd1;
      bar <= h_wrap ? 3'd0 : pc == BL ? bar + 3'd1 : bar;
      hsync <= hs ? SYNC_POL : ~SYNC_POL;
      vsync <= vs ? SYNC_POL : ~SYNC_POL;
      hblank <= hb;
      vblank <= vb;
      hpos <= hc;
      vpos <= vc;
      frame_start <= origin;
      r <= rc;
      g <= gc;
      b <= bc;
      rn <= ~rc;
      gn <= ~gc;
      bn <= ~bc;
      r_th <= therm(rc);
      g_th <= therm(gc);
      b_th <= therm(bc);
    end
  end
endmodule

// File: tb/tb_vga_dac_driver.sv
// tb_vga_dac_driver: directed checks on a reduced raster plus a tiny raster for frame-counter wrap
module tb_vga_dac_driver;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic hsync, vsync, hblank, vblank, fs;
  logic [9:0] hpos, vpos;
  logic [7:0] r, g, b, rn, gn, bn;
  logic [11:0] r_th, g_th, b_th;
  logic t_hsync, t_vsync, t_hblank, t_vblank, t_fs;
  logic [9:0] t_hpos, t_vpos;
  logic [7:0] t_r, t_g, t_b, t_rn, t_gn, t_bn;
  logic [11:0] t_r_th, t_g_th, t_b_th;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // Main raster: 80 x 48 total, 64 x 40 active, hsync 68..75, vsync lines 42..43.
  vga_dac_driver #(.CW(8), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .hpos(hpos), .vpos(vpos), .frame_start(fs),
    .r(r), .g(g), .b(b), .rn(rn), .gn(gn), .bn(bn), .r_th(r_th), .g_th(g_th), .b_th(b_th));
  // Tiny raster: 12 x 5 total, 60 clocks per frame.
  vga_dac_driver #(.CW(8), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)) tiny (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hsync(t_hsync), .vsync(t_vsync),
    .hblank(t_hblank), .vblank(t_vblank), .hpos(t_hpos), .vpos(t_vpos), .frame_start(t_fs),
    .r(t_r), .g(t_g), .b(t_b), .rn(t_rn), .gn(t_gn), .bn(t_bn), .r_th(t_r_th), .g_th(t_g_th), .b_th(t_b_th));
  task automatic wait_pos(input logic [9:0] h, input logic [9:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(hpos == h && vpos == v) && n < 10000);
    if (n >= 10000) begin
      checks++;
      errors++;
      $display("FAIL wait_pos timeout at %0d,%0d want %0d,%0d", hpos, vpos, h, v);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    checks++;
    if ({hsync, vsync, hblank, vblank, fs, hpos, vpos, r, g, b, rn, gn, bn, r_th, g_th, b_th} !==
        {5'b11000, 20'd0, 24'd0, 24'hFFFFFF, 36'd0}) begin
      errors++;
      $display("FAIL %s hs=%b vs=%b hb=%b vb=%b fs=%b pos=%0d,%0d rgb=%h/%h/%h n=%h/%h/%h th=%h/%h/%h exp idle values",
        tag, hsync, vsync, hblank, vblank, fs, hpos, vpos, r, g, b, rn, gn, bn, r_th, g_th, b_th);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({hpos, vpos, fs} !== {20'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_cycle pos=%0d,%0d fs=%b exp 0,0 fs=1", hpos, vpos, fs);
    end
  endtask
  task automatic test_hsync;
    logic ehs, ehb;
    wait_pos(10'd0, 10'd1);
    for (int i = 0; i < 80; i++) begin
      ehs = !(i >= 68 && i < 76);
      ehb = i >= 64;
      checks++;
      if ({hpos, hsync, hblank} !== {10'(i), ehs, ehb}) begin
        errors++;
        $display("FAIL hsync_line hpos=%0d hs=%b hb=%b exp %0d %b %b", hpos, hsync, hblank, i, ehs, ehb);
      end
      @(negedge clk);
    end
    checks++;
    if ({hpos, vpos, hsync} !== {10'd0, 10'd2, 1'b1}) begin
      errors++;
      $display("FAIL hsync_repeat pos=%0d,%0d hs=%b exp 0,2 1", hpos, vpos, hsync);
    end
  endtask
  task automatic test_vsync;
    int lows;
    logic evs, evb;
    lows = 0;
    wait_pos(10'd0, 10'd0);
    for (int i = 0; i < 3840; i++) begin
      evs = !(vpos >= 10'd42 && vpos < 10'd44);
      evb = vpos >= 10'd40;
      if (!vsync) lows++;
      checks++;
      if ({vsync, vblank, fs} !== {evs, evb, i == 0}) begin
        errors++;
        $display("FAIL vsync_frame i=%0d vpos=%0d vs=%b vb=%b fs=%b exp %b %b %b", i, vpos, vsync, vblank, fs, evs, evb, i == 0);
      end
      @(negedge clk);
    end
    checks++;
    if ({lows, hpos, vpos, fs} !== {32'd160, 20'd0, 1'b1}) begin
      errors++;
      $display("FAIL frame_period lows=%0d pos=%0d,%0d fs=%b exp 160 0,0 1", lows, hpos, vpos, fs);
    end
  endtask
  task automatic test_gradient;
    mode = 2'd1;
    wait_pos(10'd0, 10'd0);
    wait_pos(10'h35, 10'd5);
    checks++;
    if ({r, rn, r_th, g, gn} !== {8'h35, 8'hCA, 12'b000_111_001_001, 8'h05, 8'hFA}) begin
      errors++;
      $display("FAIL gradient r=%h rn=%h r_th=%b g=%h gn=%h exp 35 CA 000111001001 05 FA", r, rn, r_th, g, gn);
    end
    wait_pos(10'h35, 10'd44);
    checks++;
    if ({r, rn, r_th, g, b} !== {8'h00, 8'hFF, 12'd0, 16'd0}) begin
      errors++;
      $display("FAIL gradient_vblank r=%h rn=%h r_th=%b g=%h b=%h exp 00 FF 0 00 00", r, rn, r_th, g, b);
    end
  endtask
  task automatic test_bars;
    mode = 2'd2;
    wait_pos(10'd0, 10'd0);
    wait_pos(10'd0, 10'd3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({r, g, b} !== 24'h000000) begin
        errors++;
        $display("FAIL bar0 hpos=%0d rgb=%h/%h/%h exp 00/00/00", hpos, r, g, b);
      end
      @(negedge clk);
    end
    checks++;
    if ({hpos, r, g, b, b_th} !== {10'd8, 24'h0000FF, 12'hFFF}) begin
      errors++;
      $display("FAIL bar1 hpos=%0d rgb=%h/%h/%h b_th=%h exp 8 00/00/FF FFF", hpos, r, g, b, b_th);
    end
    wait_pos(10'd56, 10'd3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({r, g, b, rn} !== {24'hFFFFFF, 8'h00}) begin
        errors++;
        $display("FAIL bar7 hpos=%0d rgb=%h/%h/%h rn=%h exp FF/FF/FF 00", hpos, r, g, b, rn);
      end
      @(negedge clk);
    end
    checks++;
    if ({hpos, hblank, r, g, b} !== {10'd64, 1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL bar_blank hpos=%0d hb=%b rgb=%h/%h/%h exp 64 1 00/00/00", hpos, hblank, r, g, b);
    end
  endtask
  task automatic test_mode_change;
    mode = 2'd0;
    wait_pos(10'd0, 10'd0);
    wait_pos(10'd0, 10'd10);
    mode = 2'd3;
    wait_pos(10'd20, 10'd10);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL mode_hold_a r=%h exp 00", r);
    end
    wait_pos(10'd20, 10'd39);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL mode_hold_b r=%h exp 00", r);
    end
    wait_pos(10'd0, 10'd0);
    checks++;
    if (fs !== 1'b1) begin
      errors++;
      $display("FAIL mode_frame_start fs=%b exp 1", fs);
    end
    wait_pos(10'd16, 10'd0);
    for (int i = 16; i < 33; i++) begin
      checks++;
      if ({r, g, b} !== ((i < 32) ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL checker_v0 hpos=%0d rgb=%h/%h/%h exp %h", hpos, r, g, b, (i < 32) ? 24'hFFFFFF : 24'h000000);
      end
      @(negedge clk);
    end
    wait_pos(10'd0, 10'd16);
    checks++;
    if ({r, g, b} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL checker_v16 rgb=%h/%h/%h exp FF/FF/FF", r, g, b);
    end
  endtask
  task automatic test_enable;
    wait_pos(10'd20, 10'd1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({hpos, vpos, r, rn, hblank, fs} !== {10'd20, 10'd1, 8'hFF, 8'h00, 2'b00}) begin
        errors++;
        $display("FAIL en_hold i=%0d pos=%0d,%0d r=%h rn=%h hb=%b fs=%b exp 20,1 FF 00 0 0", i, hpos, vpos, r, rn, hblank, fs);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({hpos, vpos} !== {10'd21, 10'd1}) begin
      errors++;
      $display("FAIL en_resume pos=%0d,%0d exp 21,1", hpos, vpos);
    end
  endtask
  task automatic test_reset_mid;
    wait_pos(10'd70, 10'd5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({hpos, vpos, fs} !== {20'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_restart pos=%0d,%0d fs=%b exp 0,0 1", hpos, vpos, fs);
    end
    @(negedge clk);
    checks++;
    if ({hpos, vpos, fs} !== {10'd1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_count pos=%0d,%0d fs=%b exp 1,0 0", hpos, vpos, fs);
    end
  endtask
  task automatic test_fc_wrap;
    int n;
    mode = 2'd1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f <= 256; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!t_fs && n < 200);
      checks++;
      if (t_b !== 8'(f) || n >= 200) begin
        errors++;
        $display("FAIL fc_wrap frame=%0d b=%h exp %h waited=%0d", f, t_b, 8'(f), n);
      end
    end
  endtask
  initial begin
    test_reset;
    test_hsync;
    test_vsync;
    test_gradient;
    test_bars;
    test_mode_change;
    test_enable;
    test_reset_mid;
    test_fc_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
